// File: rtl/rbm_pkg.sv
// rtl/rbm_pkg.sv - shared types and default widths for the register bank master
package rbm_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR       = 2'd1,
    ST_RD       = 2'd2,
    ST_RD_DRAIN = 2'd3
  } state_t;

  // Remaining beats in a burst, encoded as beats minus one.
  typedef logic [ADDR_W_DEF-1:0] beat_cnt_t;

endpackage

// File: rtl/rbm_watchdog.sv
// rtl/rbm_watchdog.sv - stall counter that flags when a burst has stalled TIMEOUT cycles
module rbm_watchdog
  import rbm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Fires during the TIMEOUT-th consecutive stalled cycle.
  assign expired = stall && (cnt_q == CW'(TIMEOUT - 1));

  // Count consecutive stalls; any progress or an expiry restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!stall || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_bank_master.sv
// rtl/reg_bank_master.sv - burst master for a 16x32 register bank; RBM_WATCHDOG_EN adds a stall watchdog
module reg_bank_master
  import rbm_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_line,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_read_en,
  output logic [ADDR_W-1:0] rf_read_line,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] wline_q, wline_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              we_q, we_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              issue;
  logic              wd_expired;

`ifdef RBM_WATCHDOG_EN
  logic wd_stall;
  assign wd_stall = ((state_q == ST_WR) && !wr_valid) ||
                    (((state_q == ST_RD) || (state_q == ST_RD_DRAIN)) && rvalid_q && !rd_ready);

  rbm_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (wd_stall),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign wd_expired     = 1'b0;
`endif

  // A read is issued whenever the output slot is empty or being emptied this cycle.
  assign issue         = (state_q == ST_RD) && (!rvalid_q || rd_ready);
  assign rf_read_en    = issue;
  assign rf_read_line  = (state_q == ST_RD) ? ptr_q : '0;
  assign wr_ready      = (state_q == ST_WR);
  assign busy          = (state_q != ST_IDLE);
  assign cmd_ready     = cmd_ready_q;
  assign rf_write_en   = we_q;
  assign rf_write_line = wline_q;
  assign rf_wdata      = wdata_q;
  assign rd_valid      = rvalid_q;
  assign rd_data       = rdata_q;
  assign rd_last       = rlast_q;
  assign done          = done_q;
  assign err           = err_q;

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    wline_d  = wline_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = 1'b0;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          ptr_d   = cmd_addr;
          rem_d   = cmd_len;
          err_d   = 1'b0;
          state_d = cmd_write ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (wr_valid) begin
          we_d    = 1'b1;
          wline_d = ptr_q;
          wdata_d = wr_data;
          ptr_d   = ptr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - ADDR_W'(1);
          end
        end
      end
      ST_RD: begin
        if (rvalid_q && rd_ready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end
        if (issue) begin
          rdata_d  = rf_rdata;
          rvalid_d = 1'b1;
          rlast_d  = (rem_q == '0);
          ptr_d    = ptr_q + ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = ST_RD_DRAIN;
          end else begin
            rem_d = rem_q - ADDR_W'(1);
          end
        end
      end
      ST_RD_DRAIN: begin
        if (rvalid_q && rd_ready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wd_expired) begin
      state_d  = ST_IDLE;
      we_d     = 1'b0;
      rvalid_d = 1'b0;
      rlast_d  = 1'b0;
      err_d    = 1'b1;
      done_d   = 1'b1;
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      wline_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      wline_q     <= wline_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
      we_q        <= we_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_bank_master.sv
// tb/tb_reg_bank_master.sv - directed bench for reg_bank_master with a behavioural bank model
module tb_reg_bank_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rf_write_en;
  logic [3:0]  rf_write_line;
  logic [31:0] rf_wdata;
  logic        rf_read_en;
  logic [3:0]  rf_read_line;
  logic [31:0] rf_rdata;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] bank [16];

  reg_bank_master #(.DATA_W(32), .ADDR_W(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .rf_write_en   (rf_write_en),
    .rf_write_line (rf_write_line),
    .rf_wdata      (rf_wdata),
    .rf_read_en    (rf_read_en),
    .rf_read_line  (rf_read_line),
    .rf_rdata      (rf_rdata),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write_en) bank[rf_write_line] <= rf_wdata;
  end
  assign rf_rdata = bank[rf_read_line];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_len   = 4'd0;
    wr_valid  = v.wr;
    wr_data   = v.data;
    rd_ready  = 1'b1;
    #1 chk("vec_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    if (v.wr) begin
      cyc();
      wr_valid = 1'b0;
      chk("vec_wr_en", 32'(rf_write_en), 32'd1);
      chk("vec_wr_line", 32'(rf_write_line), 32'(v.addr));
      chk("vec_wr_data", rf_wdata, v.data);
      chk("vec_wr_done", 32'(done), 32'd1);
    end else begin
      chk("vec_rd_en", 32'(rf_read_en), 32'd1);
      chk("vec_rd_line", 32'(rf_read_line), 32'(v.addr));
      cyc();
      chk("vec_rd_valid", 32'(rd_valid), 32'd1);
      chk("vec_rd_data", rd_data, v.data);
      chk("vec_rd_last", 32'(rd_last), 32'd1);
      chk("vec_rd_early_done", 32'(done), 32'd0);
      cyc();
      chk("vec_rd_done", 32'(done), 32'd1);
      chk("vec_rd_drop", 32'(rd_valid), 32'd0);
    end
  endtask

  task automatic write_burst(input logic [3:0] addr, input logic [3:0] len, input logic [31:0] base);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    wr_valid  = 1'b1;
    wr_data   = base;
    #1 chk("wb_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    chk("wb_no_early_strobe", 32'(rf_write_en), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      cyc();
      chk("wb_en", 32'(rf_write_en), 32'd1);
      chk("wb_line", 32'(rf_write_line), (32'(addr) + 32'(i)) & 32'hF);
      chk("wb_data", rf_wdata, base + 32'(i));
      chk("wb_done", 32'(done), (i == int'(len)) ? 32'd1 : 32'd0);
      wr_data = base + 32'(i) + 32'd1;
    end
    wr_valid = 1'b0;
    chk("wb_ready_after", 32'(cmd_ready), 32'd1);
    cyc();
    chk("wb_idle_en", 32'(rf_write_en), 32'd0);
    chk("wb_idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    int          got;
    int          strobes;
    bit          stalled;
    logic [31:0] held;

    vecs[0] = '{1'b1, 4'd3,  32'h1111_1111};
    vecs[1] = '{1'b1, 4'd7,  32'h2222_2222};
    vecs[2] = '{1'b1, 4'd3,  32'h3333_3333};
    vecs[3] = '{1'b0, 4'd3,  32'h3333_3333};
    vecs[4] = '{1'b0, 4'd7,  32'h2222_2222};
    vecs[5] = '{1'b1, 4'd5,  32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 4'd5,  32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 4'd3,  32'h3333_3333};

    // reset state
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(rf_write_en), 32'd0);
    chk("rst_rd_en", 32'(rf_read_en), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #10 reset_n = 1'b1;
    cyc();
    chk("rst_ready_after", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // wrapping write burst
    write_burst(4'd14, 4'd3, 32'hA0);
    // fill the bank with its own index
    write_burst(4'd0, 4'd15, 32'd0);

    // 16-beat read with rd_ready toggling
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd0;
    cmd_len   = 4'd15;
    rd_ready  = 1'b1;
    got       = 0;
    stalled   = 1'b0;
    held      = '0;
    for (int n = 0; n < 80 && got < 16; n++) begin
      cyc();
      cmd_valid = 1'b0;
      rd_ready  = (n % 2 == 0);
      #1;
      if (stalled) begin
        chk("rs_hold_valid", 32'(rd_valid), 32'd1);
        chk("rs_hold_data", rd_data, held);
      end
      stalled = 1'b0;
      if (rd_valid) begin
        if (rd_ready) begin
          chk("rs_data", rd_data, 32'(got));
          chk("rs_last", 32'(rd_last), (got == 15) ? 32'd1 : 32'd0);
          got++;
        end else begin
          stalled = 1'b1;
          held    = rd_data;
        end
      end
    end
    chk("rs_beats", 32'(got), 32'd16);
    cyc();
    chk("rs_done", 32'(done), 32'd1);
    chk("rs_valid_drop", 32'(rd_valid), 32'd0);
    rd_ready = 1'b1;

    // command offered during an active burst is ignored
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'd8;
    cmd_len   = 4'd1;
    wr_valid  = 1'b0;
    cyc();
    cmd_write = 1'b0;
    cmd_addr  = 4'd3;
    cmd_len   = 4'd0;
    #1;
    chk("ig_cmd_ready0", 32'(cmd_ready), 32'd0);
    chk("ig_busy", 32'(busy), 32'd1);
    for (int n = 0; n < 2; n++) begin
      cyc();
      chk("ig_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("ig_no_read", 32'(rf_read_en), 32'd0);
    end
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 32'hC0;
    cyc();
    chk("ig_en0", 32'(rf_write_en), 32'd1);
    chk("ig_line0", 32'(rf_write_line), 32'd8);
    chk("ig_data0", rf_wdata, 32'hC0);
    wr_data = 32'hC1;
    cyc();
    chk("ig_line1", 32'(rf_write_line), 32'd9);
    chk("ig_data1", rf_wdata, 32'hC1);
    chk("ig_done", 32'(done), 32'd1);
    wr_valid = 1'b0;
    cyc();
    chk("ig_idle", 32'(busy), 32'd0);
    chk("ig_no_read_after", 32'(rf_read_en), 32'd0);

    // reset in the middle of a write burst
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'd10;
    cmd_len   = 4'd3;
    wr_valid  = 1'b1;
    wr_data   = 32'hB0;
    cyc();
    cmd_valid = 1'b0;
    wr_data   = 32'hB1;
    cyc();
    cyc();
    chk("mr_second_beat", rf_wdata, 32'hB1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_wr_en", 32'(rf_write_en), 32'd0);
    chk("mr_wdata", rf_wdata, 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_wr_ready", 32'(wr_ready), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    #2 reset_n = 1'b1;
    strobes = 0;
    for (int n = 0; n < 5; n++) begin
      cyc();
      if (rf_write_en) strobes++;
    end
    chk("mr_no_strobes", 32'(strobes), 32'd0);
    chk("mr_ready_after", 32'(cmd_ready), 32'd1);
    wr_valid = 1'b0;

    // watchdog: one beat then stall
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'd4;
    cmd_len   = 4'd3;
    wr_valid  = 1'b1;
    wr_data   = 32'hE0;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    chk("wd_first_beat", 32'(rf_write_en), 32'd1);
    wr_valid = 1'b0;
`ifdef RBM_WATCHDOG_EN
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k < 8) begin
        chk("wd_err_early", 32'(err), 32'd0);
        chk("wd_busy_early", 32'(busy), 32'd1);
      end else begin
        chk("wd_err", 32'(err), 32'd1);
        chk("wd_done", 32'(done), 32'd1);
        chk("wd_idle", 32'(busy), 32'd0);
      end
    end
    cyc();
    chk("wd_err_sticky", 32'(err), 32'd1);
    chk("wd_done_pulse", 32'(done), 32'd0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd5;
    cmd_len   = 4'd0;
    rd_ready  = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("wd_err_clear", 32'(err), 32'd0);
    cyc();
    chk("wd_after_rd", rd_data, 32'd5);
    cyc();
`else
    for (int k = 0; k < 100; k++) cyc();
    chk("wd_still_busy", 32'(busy), 32'd1);
    chk("wd_no_err", 32'(err), 32'd0);
    chk("wd_no_done", 32'(done), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank_master.md
Name: reg_bank_master

Overview:
Bus-side master that drives a 16-entry x 32-bit register bank through its write/read line interface. It accepts single or burst commands from a host over valid/ready, then sequences the bank's write_en/write_line or read_en/read_line pins. Write data is taken from a host stream and read data is returned on a backpressured response stream. It sits between the host/CPU-side interconnect and the register bank.

Parameters:
DATA_W, 32, data word width
ADDR_W, 4, register index width (16 entries)
TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start register index
cmd_len  in  ADDR_W  beats minus one (0..15 gives 1..16 beats)
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  host accepts read beat
rd_data  out  DATA_W  read beat data
rd_last  out  1  final beat of the burst
rf_write_en  out  1  bank write strobe
rf_write_line  out  ADDR_W  bank write index
rf_wdata  out  DATA_W  data broadcast to all bank data inputs
rf_read_en  out  1  bank read strobe
rf_read_line  out  ADDR_W  bank read index
rf_rdata  in  DATA_W  bank read bus (combinational from the bank)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at burst completion
err  out  1  watchdog abort flag (optional feature)

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. State = IDLE. All registered outputs are 0: rf_*, rd_valid, rd_data, rd_last, done, err. cmd_ready goes to 1 after reset is released.
- States: IDLE, WR, RD, RD_DRAIN.
- IDLE: cmd_ready = 1. On a cmd handshake, latch ptr = cmd_addr and rem = cmd_len. Go to WR if cmd_write = 1, otherwise RD. In all other states cmd_ready = 0 and cmd_valid is ignored.
- WR: wr_ready = 1. On a wr handshake, register rf_write_en = 1, rf_write_line = ptr and rf_wdata = wr_data for exactly the next cycle (latency 1). Then ptr = ptr + 1 mod 16, so 15 wraps to 0. If rem = 0, go to IDLE, and done pulses in the same cycle as the final rf_write_en. Otherwise decrement rem. rf_write_en = 0 in every cycle not following a handshake.
- RD: rf_read_en = (!rd_valid or rd_ready), combinational; rf_read_line = ptr.
  - At a clock edge with rf_read_en = 1: rd_data <= rf_rdata, rd_valid <= 1, rd_last <= (rem = 0), ptr increments with wrap.
  - After the last issue, go to RD_DRAIN; otherwise decrement rem.
  - With rd_ready held high, throughput is 1 beat/cycle. First rd_valid appears 2 cycles after the cmd handshake.
- rd_valid drops at the edge where rd_valid and rd_ready are both high and no new issue occurs.
- RD_DRAIN: on the handshake of the rd_last beat, go to IDLE and pulse done in the following cycle. rd_data is held stable while rd_valid = 1 and rd_ready = 0.
- The master never asserts rf_write_en and rf_read_en in the same cycle.
- Reset mid-burst: immediate return to IDLE; outstanding beats are dropped and no further rf strobes are issued.

Optional Feature:
Macro RBM_WATCHDOG_EN.
- Enabled: a counter increments on each stalled cycle, i.e. WR with wr_valid = 0, or RD/RD_DRAIN with rd_valid = 1 and rd_ready = 0.
  - The counter clears on progress.
  - When it reaches TIMEOUT: abort to IDLE, clear rd_valid, set err = 1 and pulse done.
  - err is sticky until the next cmd handshake.
- Disabled: no counter, err is tied to 0, and stalls wait indefinitely.

Decomposition:
- Package rbm_pkg holds:
  - the state enum (IDLE/WR/RD/RD_DRAIN);
  - DATA_W and ADDR_W defaults;
  - the beat-count type.
- One sub-module, rbm_watchdog (stall counter with terminal flag), instantiated only under RBM_WATCHDOG_EN. All other logic stays in one module.

Test Plan:
- Write cmd addr=14 len=3, wr_data 0xA0..0xA3 with wr_valid held high -> rf_write_en on 4 consecutive cycles with lines 14,15,0,1 and matching data; done coincides with the 4th strobe; cmd_ready=1 afterwards.
- Read cmd addr=5 len=0, bank model drives 0xDEADBEEF on line 5 -> rf_read_en one cycle after the handshake; rd_valid=1 next cycle with rd_data=0xDEADBEEF and rd_last=1; done after the handshake.
- Read cmd addr=0 len=15, rd_ready toggling 1,0,1,0 -> 16 beats in order (bank values 0..15), none lost or duplicated, rd_data stable while stalled, rd_last only on beat 16.
- Assert reset_n=0 after 2 of 4 write beats -> all outputs 0 asynchronously; after release, no rf_write_en until a new command; cmd_ready=1.
- cmd_valid=1 with a different command during an active burst -> cmd_ready=0, command ignored, burst completes unaffected.
- RBM_WATCHDOG_EN, TIMEOUT=8: write len=3, supply 1 beat then stall -> err=1 and done pulse 8 cycles after the stall begins, state IDLE. Without the macro: still busy after 100 cycles.
